speaker_arbiter: RTL and testbench
==================================

SPEAKER_ARBITER -- requirements
Module: speaker_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 6, giving the number of audio requesters.
REQ-002 The block SHALL have parameter HOLD_CYC, default 16, giving the minimum grant time in cycles before preemption.
REQ-003 The block SHALL have parameter GAP_CYC, default 4, giving the silence cycles inserted between grants when the gap feature is compiled in.
REQ-004 The block SHALL have port clk, input, 1, system clock; one clock; all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 The block SHALL have port req, input, NREQ, level request per source; a higher index has higher priority.
REQ-007 The block SHALL have port tone_in, input, NREQ, square-wave audio per source.
REQ-008 The block SHALL have port dismiss, input, 1, single-cycle debounced pulse that silences the current source.
REQ-009 The block SHALL have port grant, output, NREQ, one-hot or zero owner of the speaker.
REQ-010 The block SHALL have port speaker, output, 1, registered audio for the single shared speaker pin.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 The block SHALL have port mask, output, NREQ, sources dismissed and not yet released.

Function
REQ-013 The block SHALL compute eligible = req & ~mask each cycle.
REQ-014 The block SHALL implement states IDLE, GRANT and GAP.
REQ-015 In IDLE with eligible nonzero, the next cycle SHALL enter GRANT with grant = the highest-index eligible bit and hold_cnt = 0, giving 1-cycle request-to-grant latency.
REQ-016 In GRANT, hold_cnt SHALL increment each cycle and saturate at HOLD_CYC-1.
REQ-017 In GRANT, if the granted bit is no longer eligible, the block SHALL leave GRANT on the next cycle regardless of hold_cnt.
REQ-018 In GRANT, if a higher-index eligible bit exists and hold_cnt == HOLD_CYC-1, the block SHALL leave GRANT on the next cycle (preemption); lower-index requests SHALL never preempt.
REQ-019 A dismiss pulse in GRANT SHALL set mask at the granted index on the next edge; a dismiss pulse in IDLE or GAP SHALL be ignored.
REQ-020 A mask bit SHALL clear on the cycle after its req bit is sampled low; a masked source SHALL re-arm only by dropping and re-raising req.
REQ-021 When dismiss and preemption occur in the same cycle, dismiss SHALL take effect (mask set) and the exit SHALL be treated as a REQ-017 exit.
REQ-022 On exit from GRANT, grant SHALL become zero on the following cycle.
REQ-023 speaker SHALL be driven as |(tone_in & grant), registered (1-cycle latency), and SHALL be 0 whenever grant is zero.
REQ-024 The gap counter SHALL be sized clog2(GAP_CYC+1); the hold counter SHALL be sized clog2(HOLD_CYC).
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL set state = IDLE, grant = 0, speaker = 0, busy = 0, mask = 0 and all counters to 0.
REQ-027 A reset asserted during GRANT or GAP SHALL silence speaker on the next edge, with no gap sequence.

Configuration
REQ-028 With macro SPK_ARB_GAP_EN defined, every GRANT exit SHALL enter GAP for exactly GAP_CYC cycles (grant = 0, speaker = 0) and then enter IDLE.
REQ-029 Without SPK_ARB_GAP_EN, every GRANT exit SHALL go directly to IDLE, GAP SHALL be unreachable and the gap counter SHALL be omitted.

Structure
REQ-030 Package spk_arb_pkg SHALL hold the state enum and the source index constants SRC_CHIME = 0, SRC_ALR0..SRC_ALR3 = 1..4 and SRC_CD = 5.
REQ-031 A sub-module pri_onehot SHALL map an NREQ vector to the one-hot of its highest set bit, or zero if none is set.

Verification (HOLD_CYC = 16, GAP_CYC = 4)
REQ-032 Single request: req = 6'b000010 at cycle 0 -> grant = 6'b000010 at cycle 1, busy = 1, speaker follows tone_in[1] with 1 cycle of lag.
REQ-033 Preemption: alarm0 is granted, then req[5] rises at hold_cnt = 3 -> grant stays 6'b000010 until hold_cnt = 15, then moves to 6'b100000 (after 4 zero cycles when the gap feature is compiled in).
REQ-034 Dismiss: a dismiss pulse while req[5] is granted and req[0] is pending -> mask = 6'b100000, grant moves to 6'b000001; after req[5] drops, mask = 0 on the next cycle.
REQ-035 Simultaneous events: dismiss coincides with a preemption-eligible cycle -> the dismissed index is masked and the next grant goes to the highest remaining eligible bit.
REQ-036 Reset mid-operation: rst pulse during GRANT -> all outputs 0 at the next edge; if req is still high, grant reasserts 1 cycle after rst falls.
REQ-037 Build with and without SPK_ARB_GAP_EN: gap cycles with grant = 0 appear only in the build with the macro defined.

Source files
------------

// File: rtl/spk_arb_pkg.sv
// Shared types and source indices for the speaker arbiter.
package spk_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int unsigned SRC_CHIME = 0;
  localparam int unsigned SRC_ALR0  = 1;
  localparam int unsigned SRC_ALR1  = 2;
  localparam int unsigned SRC_ALR2  = 3;
  localparam int unsigned SRC_ALR3  = 4;
  localparam int unsigned SRC_CD    = 5;

endpackage

// File: rtl/speaker_arbiter_pri.sv
// Highest-set-bit to one-hot encoder; zero in, zero out.
module pri_onehot #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec[i]) begin
        onehot_c    = '0;
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/speaker_arbiter.sv
// Priority arbiter for one shared speaker pin with minimum hold time and dismiss masking.
// Optional silence gap between grants: define SPK_ARB_GAP_EN.
module speaker_arbiter
  import spk_arb_pkg::*;
#(
  parameter int unsigned NREQ     = SRC_CD + 1,
  parameter int unsigned HOLD_CYC = 16,
  parameter int unsigned GAP_CYC  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] tone_in,
  input  logic            dismiss,
  output logic [NREQ-1:0] grant,
  output logic            speaker,
  output logic            busy,
  output logic [NREQ-1:0] mask
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC - 1);

  if (HOLD_CYC < 1 || GAP_CYC < 1) begin : g_bad_params
    $error("speaker_arbiter: HOLD_CYC and GAP_CYC must be at least 1");
  end

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   top_c;
  logic              lost;
  logic              preempt;
  logic              leave;
  logic [NREQ-1:0]   mask_set;

`ifdef SPK_ARB_GAP_EN
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  assign eligible = req & ~mask;

  pri_onehot #(.N(NREQ)) u_pri (
    .vec      (eligible),
    .onehot_c (top_c)
  );

  // One-hot vectors compare like their indices, so top_c > grant means a higher requester waits.
  assign lost     = ~|(grant & eligible) | dismiss;
  assign preempt  = (top_c > grant) && (hold_cnt == HOLD_MAX);
  assign leave    = lost | preempt;
  assign mask_set = (state == ST_GRANT && dismiss) ? grant : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant    <= '0;
      speaker  <= 1'b0;
      busy     <= 1'b0;
      mask     <= '0;
      hold_cnt <= '0;
`ifdef SPK_ARB_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      mask <= (mask & req) | mask_set;
      case (state)
        ST_IDLE: begin
          hold_cnt <= '0;
          if (|eligible) begin
            state   <= ST_GRANT;
            grant   <= top_c;
            speaker <= |(tone_in & top_c);
            busy    <= 1'b1;
          end else begin
            grant   <= '0;
            speaker <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (leave) begin
            grant    <= '0;
            speaker  <= 1'b0;
            hold_cnt <= '0;
`ifdef SPK_ARB_GAP_EN
            state    <= ST_GAP;
            busy     <= 1'b1;
            gap_cnt  <= '0;
`else
            state    <= ST_IDLE;
            busy     <= 1'b0;
`endif
          end else begin
            speaker <= |(tone_in & grant);
            busy    <= 1'b1;
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
`ifdef SPK_ARB_GAP_EN
        ST_GAP: begin
          grant   <= '0;
          speaker <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
            busy    <= 1'b1;
          end
        end
`endif
        default: begin
          state    <= ST_IDLE;
          grant    <= '0;
          speaker  <= 1'b0;
          busy     <= 1'b0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speaker_arbiter.sv
// Self-checking bench for speaker_arbiter: index-level model plus directed literal checks.
module tb_speaker_arbiter;

  localparam int NREQ     = 6;
  localparam int HOLD_CYC = 16;
  localparam int GAP_CYC  = 4;
`ifdef SPK_ARB_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif
  localparam int ZERO = GAP_ON ? GAP_CYC + 1 : 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] tone_in = '0;
  logic            dismiss = 1'b0;
  logic [NREQ-1:0] grant;
  logic            speaker;
  logic            busy;
  logic [NREQ-1:0] mask;

  int n_cmp  = 0;
  int n_fail = 0;

  speaker_arbiter #(.NREQ(NREQ), .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .tone_in (tone_in),
    .dismiss (dismiss),
    .grant   (grant),
    .speaker (speaker),
    .busy    (busy),
    .mask    (mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Model: who owns the speaker, for how long, and how much silence remains.
  int              m_owner  = -1;
  int              m_held   = 0;
  int              m_silent = 0;
  logic [NREQ-1:0] m_mask   = '0;
  logic [NREQ-1:0] exp_grant = '0;
  logic            exp_spk  = 1'b0;
  logic            exp_busy = 1'b0;
  bit              m_ok     = 1'b0;

  always @(posedge clk) begin : model
    int own, hld, sil, hi;
    logic [NREQ-1:0] el, msk;
    if (rst) begin
      own = -1; hld = 0; sil = 0; msk = '0;
    end else begin
      own = m_owner; hld = m_held; sil = m_silent;
      el  = req & ~m_mask;
      msk = m_mask & req;
      hi  = -1;
      for (int i = 0; i < NREQ; i++) if (el[i]) hi = i;
      if (own >= 0) begin
        if (dismiss) msk[own] = 1'b1;
        if (!el[own] || dismiss || (hi > own && hld == HOLD_CYC - 1)) begin
          own = -1;
          hld = 0;
          sil = GAP_ON ? GAP_CYC : 0;
        end else if (hld < HOLD_CYC - 1) begin
          hld++;
        end
      end else if (sil > 0) begin
        sil--;
      end else if (hi >= 0) begin
        own = hi;
        hld = 0;
      end
    end
    m_owner   <= own;
    m_held    <= hld;
    m_silent  <= sil;
    m_mask    <= msk;
    exp_grant <= (own >= 0) ? NREQ'(1 << own) : '0;
    exp_spk   <= (own >= 0 && !rst) ? tone_in[own] : 1'b0;
    exp_busy  <= (own >= 0) || (sil > 0);
    m_ok      <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("grant",   32'(grant),   32'(exp_grant));
      chk("speaker", 32'(speaker), 32'(exp_spk));
      chk("busy",    32'(busy),    32'(exp_busy));
      chk("mask",    32'(mask),    32'(m_mask));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      tone_in = NREQ'($urandom);
    end
  end

  initial begin
    // reset state
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_mask",  32'(mask),  32'd0);
    chk("rst_spk",   32'(speaker), 32'd0);
    rst = 1'b0;

    // single request, then preemption by req[5] after full hold
    req = 6'b000010;
    tick(1);
    chk("single_grant", 32'(grant), 32'b000010);
    chk("single_busy",  32'(busy),  32'd1);
    tick(3);
    req = 6'b100010;
    tick(12);
    chk("hold_keeps", 32'(grant), 32'b000010);
    tick(1);
    chk("preempt_zero", 32'(grant), 32'd0);
    tick(ZERO);
    chk("preempt_new", 32'(grant), 32'b100000);

    // dismiss the top source while req[0] waits
    req = 6'b100001;
    tick(1);
    dismiss = 1'b1;
    tick(1);
    dismiss = 1'b0;
    chk("dismiss_mask",  32'(mask),  32'b100000);
    chk("dismiss_grant", 32'(grant), 32'd0);
    tick(ZERO);
    chk("dismiss_next", 32'(grant), 32'b000001);
    chk("mask_held",    32'(mask),  32'b100000);
    req = 6'b000001;
    tick(1);
    chk("mask_release", 32'(mask), 32'd0);

    // dismiss on a preemption-eligible cycle
    req = 6'b000000;
    tick(ZERO + 1);
    req = 6'b000100;
    tick(1);
    chk("sim_grant", 32'(grant), 32'b000100);
    req = 6'b011100;
    tick(14);
    chk("sim_hold", 32'(grant), 32'b000100);
    tick(1);
    dismiss = 1'b1;
    tick(1);
    dismiss = 1'b0;
    chk("sim_mask",  32'(mask),  32'b000100);
    chk("sim_zero",  32'(grant), 32'd0);
    tick(ZERO);
    chk("sim_next", 32'(grant), 32'b010000);

    // reset mid-grant
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_grant", 32'(grant),   32'd0);
    chk("mid_rst_spk",   32'(speaker), 32'd0);
    chk("mid_rst_busy",  32'(busy),    32'd0);
    chk("mid_rst_mask",  32'(mask),    32'd0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_grant", 32'(grant), 32'b010000);

    // lower-index requests never preempt
    tick(20);
    chk("no_low_preempt", 32'(grant), 32'b010000);

    // dismiss while idle is ignored
    req = 6'b000000;
    tick(ZERO + 2);
    dismiss = 1'b1;
    tick(1);
    dismiss = 1'b0;
    chk("idle_dismiss_mask", 32'(mask), 32'd0);
    chk("idle_busy",         32'(busy), 32'd0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
